// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared FSM state, register-zero constant and default sizing
package hazard_stall_unit_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter: up counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || clear) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush control for load-use, taken branches and memory waits
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             RS1Used_ID,
  input  logic             RS2Used_ID,
  input  logic [4:0]       RD_EX,
  input  logic             RegWEn_EX,
  input  logic             MemRead_EX,
  input  logic             BrTaken_EX,
  input  logic             DMemReq_MA,
  input  logic             DMemReady,
  output logic             StallPC,
  output logic             StallIF_ID,
  output logic             StallID_EX,
  output logic             StallEX_MA,
  output logic             FlushIF_ID,
  output logic             FlushID_EX,
  output logic             FlushMA_WB,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state;
  logic [WW-1:0] wait_q;
  logic mem_freeze, load_use, frz, br, lu;
  always_comb begin
    mem_freeze = (state == RUN && DMemReq_MA && !DMemReady) || (state == MEM_WAIT && !DMemReady);
    load_use = MemRead_EX && RegWEn_EX && RD_EX != REG_ZERO &&
               ((RS1Used_ID && RS1_ID == RD_EX) || (RS2Used_ID && RS2_ID == RD_EX));
    frz = !reset && (state == ERROR || mem_freeze);
    br = !reset && !frz && BrTaken_EX;
    lu = !reset && !frz && !BrTaken_EX && load_use;
    StallPC = frz || lu;
    StallIF_ID = frz || lu;
    StallID_EX = frz;
    StallEX_MA = frz;
    FlushMA_WB = frz;
    FlushIF_ID = br;
    FlushID_EX = br || lu;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      MemErr <= 1'b0;
    end else begin
      case (state)
        RUN: state <= (DMemReq_MA && !DMemReady) ? MEM_WAIT : RUN;
        MEM_WAIT:
          if (DMemReady) state <= RUN;
          else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
            state <= ERROR;
            MemErr <= 1'b1;
          end
        ERROR: state <= ERROR;
        default: state <= RUN;
      endcase
    end
  // counts every frozen RUN/MEM_WAIT cycle, so entering MEM_WAIT leaves it at 1
  sat_counter #(.W(WW)) u_wait (
    .clk(clk), .reset(reset), .clear(state == MEM_WAIT && DMemReady),
    .inc(mem_freeze), .q(wait_q)
  );
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(StallPC), .q(StallCount)
  );
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors with hand-computed stall/flush expectations
module tb_hazard_stall_unit;
  logic clk = 0, reset = 1;
  logic [4:0] RS1_ID, RS2_ID, RD_EX;
  logic RS1Used_ID, RS2Used_ID, RegWEn_EX, MemRead_EX, BrTaken_EX, DMemReq_MA, DMemReady;
  logic StallPC, StallIF_ID, StallID_EX, StallEX_MA, FlushIF_ID, FlushID_EX, FlushMA_WB, MemErr;
  logic [15:0] StallCount;
  int total = 0, bad = 0;
  localparam logic [6:0] NONE = 7'b0000000, FRZ = 7'b1111001, BR = 7'b0000110, LU = 7'b1100010;
  wire [6:0] ctl = {StallPC, StallIF_ID, StallID_EX, StallEX_MA, FlushIF_ID, FlushID_EX, FlushMA_WB};
  always #5 clk = ~clk;
  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .RS1Used_ID(RS1Used_ID), .RS2Used_ID(RS2Used_ID), .RD_EX(RD_EX),
    .RegWEn_EX(RegWEn_EX), .MemRead_EX(MemRead_EX), .BrTaken_EX(BrTaken_EX),
    .DMemReq_MA(DMemReq_MA), .DMemReady(DMemReady), .StallPC(StallPC),
    .StallIF_ID(StallIF_ID), .StallID_EX(StallID_EX), .StallEX_MA(StallEX_MA),
    .FlushIF_ID(FlushIF_ID), .FlushID_EX(FlushID_EX), .FlushMA_WB(FlushMA_WB),
    .MemErr(MemErr), .StallCount(StallCount)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic we, input logic mr, input logic br_t,
                       input logic req, input logic rdy);
    {RS1_ID, RS2_ID, RS1Used_ID, RS2Used_ID, RD_EX} = {rs1, rs2, u1, u2, rd};
    {RegWEn_EX, MemRead_EX, BrTaken_EX, DMemReq_MA, DMemReady} = {we, mr, br_t, req, rdy};
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(5, 0, 1, 0, 5, 1, 1, 1, 1, 0);
    tick;
    chk("reset_ctl", ctl, NONE);
    tick;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", StallCount, 0);
    chk("rst_err", MemErr, 0);
    chk("idle_ctl", ctl, NONE);
    drive(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    chk("lu_rs1", ctl, LU);
    tick;
    chk("lu_cnt1", StallCount, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_gone", ctl, NONE);
    drive(1, 9, 1, 1, 9, 1, 1, 0, 0, 0);
    chk("lu_rs2", ctl, LU);
    tick;
    chk("lu_cnt2", StallCount, 2);
    drive(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    chk("x0_none", ctl, NONE);
    drive(3, 7, 1, 0, 7, 1, 1, 0, 0, 0);
    chk("rs2_unused", ctl, NONE);
    drive(7, 0, 1, 0, 7, 0, 1, 0, 0, 0);
    chk("no_regwen", ctl, NONE);
    drive(7, 0, 1, 0, 7, 1, 0, 0, 0, 0);
    chk("not_load", ctl, NONE);
    drive(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
    chk("br_over_lu", ctl, BR);
    tick;
    chk("br_cnt", StallCount, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mw_frz", ctl, FRZ);
      tick;
    end
    DMemReady = 1;
    #1;
    chk("mw_done", ctl, NONE);
    tick;
    chk("mw_cnt", StallCount, 5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("zero_wait", ctl, NONE);
    tick;
    chk("zw_cnt", StallCount, 5);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("frz_br0", ctl, FRZ);
    tick;
    chk("frz_br1", ctl, FRZ);
    tick;
    DMemReady = 1;
    #1;
    chk("br_after", ctl, BR);
    tick;
    chk("frzbr_cnt", StallCount, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("to_frz", ctl, FRZ);
      tick;
    end
    chk("to_noerr", MemErr, 0);
    tick;
    chk("to_err", MemErr, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("err_frz", ctl, FRZ);
    tick;
    chk("err_cnt", StallCount, 12);
    chk("err_sticky", MemErr, 1);
    reset = 1;
    #1;
    chk("rst_ctl", ctl, NONE);
    tick;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("post_err", MemErr, 0);
    chk("post_cnt", StallCount, 0);
    chk("post_run", ctl, NONE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
